stage_sequencer: RTL and testbench

Multi-cycle control sequencer for the four-phase processor core: it produces one-hot clock enables for fetch, decode, execute and writeback so that no stage ever uses a gated clock. It also holds execute while a RAM load/store completes, and traps on decode errors or memory timeouts. It provides run-control (halt, single-step, resume) and an instructions-retired counter. It sits at the processor top level, between the RAM stall handshake and every pipeline register's enable.

---
 rtl/processor_control_pkg.sv | 21 ++
 rtl/stall_watchdog.sv | 33 +++
 rtl/stage_sequencer.sv | 123 ++++++++++++
 tb/tb_stage_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_control_pkg.sv
// Shared types and constants for the four-phase core's control sequencer:
// sequencer states, trap cause codes and the default memory watchdog limit.
package processor_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5,
        ST_TRAPPED   = 3'd6
    } seq_state_t;

    localparam logic [1:0] TRAP_NONE        = 2'd0;
    localparam logic [1:0] TRAP_DECODE      = 2'd1;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'd2;

    localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;

endpackage

// File: rtl/stall_watchdog.sv
// Counts cycles spent waiting on the RAM; expired flags the last cycle the
// sequencer may still wait before it must trap.
module stall_watchdog
    import processor_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam logic [15:0] TERMINAL = 16'(MEM_TIMEOUT - 1);

    logic [15:0] count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == TERMINAL);

endmodule

// File: rtl/stage_sequencer.sv
// Four-phase stage-enable sequencer: one-hot fetch/decode/execute/writeback
// enables, RAM stall hold, trap handling, run-control and retire counter.
module stage_sequencer
    import processor_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = DEFAULT_MEM_TIMEOUT,
    parameter int unsigned RETIRE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mem_access,
    input  logic                    mem_done,
    input  logic                    decoding_error,
    input  logic                    halt_request,
    input  logic                    resume,
    input  logic                    step,
    output logic                    fetch_en,
    output logic                    decode_en,
    output logic                    execute_en,
    output logic                    writeback_en,
    output logic                    rd_write_strobe,
    output logic                    pc_update_strobe,
    output logic                    halted,
    output logic                    trapped,
    output logic [1:0]              trap_cause,
    output logic [RETIRE_WIDTH-1:0] retired_count
);

    seq_state_t state, state_next;
    logic       step_pending, step_pending_next;
    logic [1:0] trap_cause_next;
    logic       wd_clear, wd_incr, wd_expired;

    stall_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .incr    (wd_incr),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_FETCH;
            step_pending  <= 1'b0;
            trap_cause    <= TRAP_NONE;
            retired_count <= '0;
        end else begin
            state        <= state_next;
            step_pending <= step_pending_next;
            trap_cause   <= trap_cause_next;
            if (state == ST_WRITEBACK) begin
                retired_count <= retired_count + RETIRE_WIDTH'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default before the case so that
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next        = state;
        step_pending_next = step_pending;
        trap_cause_next   = trap_cause;
        wd_clear          = 1'b0;
        wd_incr           = 1'b0;
        unique case (state)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXECUTE;
            ST_EXECUTE: begin
                if (decoding_error) begin
                    state_next      = ST_TRAPPED;
                    trap_cause_next = TRAP_DECODE;
                end else if (mem_access) begin
                    state_next = ST_MEM_WAIT;
                    wd_clear   = 1'b1;
                end else begin
                    state_next = ST_WRITEBACK;
                end
            end
            ST_MEM_WAIT: begin
                // A completion on the terminal cycle still wins over the timeout.
                if (mem_done) begin
                    state_next = ST_WRITEBACK;
                end else if (wd_expired) begin
                    state_next      = ST_TRAPPED;
                    trap_cause_next = TRAP_MEM_TIMEOUT;
                end else begin
                    wd_incr = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                if (halt_request || step_pending) begin
                    state_next        = ST_HALTED;
                    step_pending_next = 1'b0;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_next        = ST_FETCH;
                    step_pending_next = 1'b0;
                end else if (step) begin
                    state_next        = ST_FETCH;
                    step_pending_next = 1'b1;
                end
            end
            ST_TRAPPED: state_next = ST_TRAPPED;
            default:    state_next = ST_FETCH;
        endcase
    end

    // The reset state is FETCH, but no stage may be enabled while reset is held.
    assign fetch_en         = reset_n && (state == ST_FETCH);
    assign decode_en        = (state == ST_DECODE);
    assign execute_en       = (state == ST_EXECUTE);
    assign writeback_en     = (state == ST_WRITEBACK);
    assign rd_write_strobe  = (state == ST_WRITEBACK);
    assign pc_update_strobe = (state == ST_WRITEBACK);
    assign halted           = (state == ST_HALTED);
    assign trapped          = (state == ST_TRAPPED);

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a directed vector table, corner
// sequences for traps and reset, and randomized stimulus against a model.
module tb_stage_sequencer;

    localparam int unsigned TIMEOUT = 4;

    localparam logic [5:0] I_MA = 6'b100000;
    localparam logic [5:0] I_MD = 6'b010000;
    localparam logic [5:0] I_DE = 6'b001000;
    localparam logic [5:0] I_HR = 6'b000100;
    localparam logic [5:0] I_RS = 6'b000010;
    localparam logic [5:0] I_ST = 6'b000001;

    localparam logic [3:0] EN_F = 4'b1000;
    localparam logic [3:0] EN_D = 4'b0100;
    localparam logic [3:0] EN_E = 4'b0010;
    localparam logic [3:0] EN_W = 4'b0001;
    localparam logic [3:0] EN_N = 4'b0000;

    typedef struct {
        logic [5:0] stim;
        logic [3:0] en;
        bit         h;
        bit         t;
        logic [1:0] c;
        int         r;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_access = 1'b0, mem_done = 1'b0, decoding_error = 1'b0;
    logic        halt_request = 1'b0, resume = 1'b0, step = 1'b0;
    logic        fetch_en, decode_en, execute_en, writeback_en;
    logic        rd_write_strobe, pc_update_strobe, halted, trapped;
    logic [1:0]  trap_cause;
    logic [31:0] retired_count;

    int n_cmp = 0;
    int n_bad = 0;

    stage_sequencer #(.MEM_TIMEOUT(TIMEOUT), .RETIRE_WIDTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_access       (mem_access),
        .mem_done         (mem_done),
        .decoding_error   (decoding_error),
        .halt_request     (halt_request),
        .resume           (resume),
        .step             (step),
        .fetch_en         (fetch_en),
        .decode_en        (decode_en),
        .execute_en       (execute_en),
        .writeback_en     (writeback_en),
        .rd_write_strobe  (rd_write_strobe),
        .pc_update_strobe (pc_update_strobe),
        .halted           (halted),
        .trapped          (trapped),
        .trap_cause       (trap_cause),
        .retired_count    (retired_count)
    );

    always #5 clk = ~clk;

    // Expected vector: {enables, both strobes, halted, trapped, cause, retired}.
    function automatic logic [41:0] pack(logic [3:0] en, bit h, bit t, logic [1:0] c, int r);
        return {en, en[0], en[0], h, t, c, 32'(r)};
    endfunction

    function automatic logic [41:0] dut_vec();
        return {fetch_en, decode_en, execute_en, writeback_en, rd_write_strobe,
                pc_update_strobe, halted, trapped, trap_cause, retired_count};
    endfunction

    function automatic vec_t mk(logic [3:0] en, bit h, int r, logic [5:0] stim);
        vec_t v;
        v.stim = stim; v.en = en; v.h = h; v.t = 1'b0; v.c = 2'd0; v.r = r;
        return v;
    endfunction

    task automatic check(string name, logic [41:0] act, logic [41:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] stim);
        {mem_access, mem_done, decoding_error, halt_request, resume, step} = stim;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(string name, logic [41:0] exp, logic [5:0] stim);
        check(name, dut_vec(), exp);
        drive(stim);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(6'd0);
        tick();
        tick();
        check("reset_values", dut_vec(), pack(EN_N, 0, 0, 0, 0));
        reset_n = 1'b1;
        #1;
    endtask

    // Behavioural model: tracks which stage of the current instruction is
    // active and times the memory wait by absolute cycle numbers.
    localparam int M_RUN = 0, M_HALT = 1, M_TRAP = 2;
    int          m_mode, m_stage, m_cycle, m_wait_entry;
    bit          m_step;
    logic [1:0]  m_cause;
    logic [31:0] m_retired;

    task automatic model_reset();
        m_mode = M_RUN; m_stage = 0; m_cycle = 0; m_wait_entry = 0;
        m_step = 1'b0; m_cause = 2'd0; m_retired = 32'd0;
    endtask

    function automatic logic [41:0] model_expect();
        logic [3:0] en;
        en = EN_N;
        if (m_mode == M_RUN) begin
            case (m_stage)
                0: en = EN_F;
                1: en = EN_D;
                2: en = EN_E;
                4: en = EN_W;
                default: en = EN_N;
            endcase
        end
        return pack(en, m_mode == M_HALT, m_mode == M_TRAP, m_cause, int'(m_retired));
    endfunction

    task automatic model_advance(logic [5:0] stim);
        bit ma, md, de, hr, rs, st;
        {ma, md, de, hr, rs, st} = stim;
        if (m_mode == M_HALT) begin
            if (rs) begin m_mode = M_RUN; m_stage = 0; m_step = 1'b0; end
            else if (st) begin m_mode = M_RUN; m_stage = 0; m_step = 1'b1; end
        end else if (m_mode == M_RUN) begin
            case (m_stage)
                0: m_stage = 1;
                1: m_stage = 2;
                2: begin
                    if (de) begin m_mode = M_TRAP; m_cause = 2'd1; end
                    else if (ma) begin m_stage = 3; m_wait_entry = m_cycle + 1; end
                    else m_stage = 4;
                end
                3: begin
                    if (md) m_stage = 4;
                    else if (m_cycle + 1 - m_wait_entry == int'(TIMEOUT)) begin
                        m_mode = M_TRAP; m_cause = 2'd2;
                    end
                end
                default: begin
                    m_retired = m_retired + 32'd1;
                    if (hr || m_step) begin m_mode = M_HALT; m_step = 1'b0; end
                    else m_stage = 0;
                end
            endcase
        end
        m_cycle++;
    endtask

    vec_t tbl[32];

    initial begin
        // ALU x2, load with the last-possible mem_done, halt, step, resume+step.
        tbl[0]  = mk(EN_F, 0, 0, 6'd0);         tbl[1]  = mk(EN_D, 0, 0, 6'd0);
        tbl[2]  = mk(EN_E, 0, 0, 6'd0);         tbl[3]  = mk(EN_W, 0, 0, 6'd0);
        tbl[4]  = mk(EN_F, 0, 1, 6'd0);         tbl[5]  = mk(EN_D, 0, 1, 6'd0);
        tbl[6]  = mk(EN_E, 0, 1, 6'd0);         tbl[7]  = mk(EN_W, 0, 1, 6'd0);
        tbl[8]  = mk(EN_F, 0, 2, 6'd0);         tbl[9]  = mk(EN_D, 0, 2, I_MD);
        tbl[10] = mk(EN_E, 0, 2, I_MA | I_MD);  tbl[11] = mk(EN_N, 0, 2, 6'd0);
        tbl[12] = mk(EN_N, 0, 2, 6'd0);         tbl[13] = mk(EN_N, 0, 2, 6'd0);
        tbl[14] = mk(EN_N, 0, 2, I_MD);         tbl[15] = mk(EN_W, 0, 2, 6'd0);
        tbl[16] = mk(EN_F, 0, 3, I_ST | I_RS);  tbl[17] = mk(EN_D, 0, 3, I_HR);
        tbl[18] = mk(EN_E, 0, 3, I_HR);         tbl[19] = mk(EN_W, 0, 3, I_HR);
        tbl[20] = mk(EN_N, 1, 4, I_ST);         tbl[21] = mk(EN_F, 0, 4, 6'd0);
        tbl[22] = mk(EN_D, 0, 4, 6'd0);         tbl[23] = mk(EN_E, 0, 4, 6'd0);
        tbl[24] = mk(EN_W, 0, 4, 6'd0);         tbl[25] = mk(EN_N, 1, 5, I_HR | I_RS | I_ST);
        tbl[26] = mk(EN_F, 0, 5, 6'd0);         tbl[27] = mk(EN_D, 0, 5, 6'd0);
        tbl[28] = mk(EN_E, 0, 5, 6'd0);         tbl[29] = mk(EN_W, 0, 5, 6'd0);
        tbl[30] = mk(EN_F, 0, 6, 6'd0);         tbl[31] = mk(EN_D, 0, 6, 6'd0);

        #1;
        check("in_reset", dut_vec(), pack(EN_N, 0, 0, 0, 0));
        do_reset();
        for (int i = 0; i < 32; i++) begin
            expect_cycle($sformatf("table[%0d]", i),
                         pack(tbl[i].en, tbl[i].h, tbl[i].t, tbl[i].c, tbl[i].r), tbl[i].stim);
        end

        // Memory timeout: MEM_WAIT entered on cycle 4, trap visible on cycle 8.
        do_reset();
        expect_cycle("tmo_f", pack(EN_F, 0, 0, 0, 0), 6'd0);
        expect_cycle("tmo_d", pack(EN_D, 0, 0, 0, 0), 6'd0);
        expect_cycle("tmo_e", pack(EN_E, 0, 0, 0, 0), I_MA);
        for (int k = 0; k < 4; k++)
            expect_cycle($sformatf("tmo_wait[%0d]", k), pack(EN_N, 0, 0, 0, 0), 6'd0);
        for (int k = 0; k < 6; k++)
            expect_cycle($sformatf("tmo_trapped[%0d]", k), pack(EN_N, 0, 1, 2, 0),
                         I_RS | I_ST | I_MD | I_HR);

        // Decode error beats mem_access; trap is visible straight after EXECUTE.
        do_reset();
        expect_cycle("dec_f", pack(EN_F, 0, 0, 0, 0), 6'd0);
        expect_cycle("dec_d", pack(EN_D, 0, 0, 0, 0), 6'd0);
        expect_cycle("dec_e", pack(EN_E, 0, 0, 0, 0), I_MA | I_DE);
        expect_cycle("dec_trapped0", pack(EN_N, 0, 1, 1, 0), I_MD);
        expect_cycle("dec_trapped1", pack(EN_N, 0, 1, 1, 0), I_RS);

        // Reset dropped mid MEM_WAIT.
        do_reset();
        expect_cycle("rst_f", pack(EN_F, 0, 0, 0, 0), 6'd0);
        expect_cycle("rst_d", pack(EN_D, 0, 0, 0, 0), 6'd0);
        expect_cycle("rst_e", pack(EN_E, 0, 0, 0, 0), I_MA);
        check("rst_wait", dut_vec(), pack(EN_N, 0, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        check("rst_async", dut_vec(), pack(EN_N, 0, 0, 0, 0));
        tick();
        check("rst_held", dut_vec(), pack(EN_N, 0, 0, 0, 0));
        reset_n = 1'b1;
        #1;
        expect_cycle("rst_release_f", pack(EN_F, 0, 0, 0, 0), 6'd0);
        expect_cycle("rst_release_d", pack(EN_D, 0, 0, 0, 0), 6'd0);

        // Randomized run against the model, with resets to escape traps.
        do_reset();
        model_reset();
        begin
            int trap_age;
            logic [5:0] stim;
            trap_age = 0;
            for (int i = 0; i < 4000; i++) begin
                check($sformatf("rand[%0d]", i), dut_vec(), model_expect());
                trap_age = (m_mode == M_TRAP) ? trap_age + 1 : 0;
                if (trap_age > 4 || $urandom_range(0, 599) == 0) begin
                    reset_n = 1'b0;
                    drive(6'd0);
                    #1;
                    check($sformatf("rand_rst[%0d]", i), dut_vec(), pack(EN_N, 0, 0, 0, 0));
                    tick();
                    reset_n = 1'b1;
                    #1;
                    model_reset();
                    trap_age = 0;
                end else begin
                    stim[5] = ($urandom_range(0, 2) == 0);
                    stim[4] = ($urandom_range(0, 1) == 0);
                    stim[3] = ($urandom_range(0, 79) == 0);
                    stim[2] = ($urandom_range(0, 7) == 0);
                    stim[1] = ($urandom_range(0, 3) == 0);
                    stim[0] = ($urandom_range(0, 2) == 0);
                    drive(stim);
                    model_advance(stim);
                    tick();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
